ramp_pattern_checker: RTL and testbench

//  Receiving end of the ramp/hold test-stimulus stream that input_fsm drives into the DSM datapath.

---
 rtl/ramp_pattern_checker.sv | 181 ++++++++++++++++++
 tb/tb_ramp_pattern_checker.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_pattern_checker.sv
// Receive-side checker for the ramp/hold trapezoid stimulus: locks onto the pattern,
// flags deviations and counts error-free periods.
module ramp_pattern_checker #(
   parameter int DATA_WIDTH  = 16,
   parameter int HOLD_CYCLES = 1000,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic                  i_clr,
   output logic                  o_locked,
   output logic [2:0]            o_phase,
   output logic                  o_err_pulse,
   output logic                  o_err_sticky,
   output logic [CNT_WIDTH-1:0]  o_err_count,
   output logic [CNT_WIDTH-1:0]  o_period_count
);
   localparam int RUN_LEN = HOLD_CYCLES + 1;
   localparam int RC_W    = $clog2(RUN_LEN + 1);
   localparam logic [RC_W-1:0] RUN_LEN_C = RC_W'(RUN_LEN);

   typedef enum logic [2:0] {
      PH_SEEK    = 3'd0,
      PH_RAMP_UP = 3'd1,
      PH_HOLD_HI = 3'd2,
      PH_RAMP_DN = 3'd3,
      PH_HOLD_LO = 3'd4
   } phase_e;

   typedef enum logic [1:0] {CLS_UP, CLS_FLAT, CLS_DOWN, CLS_BAD} cls_e;

   function automatic phase_e next_phase(phase_e p);
      case (p)
         PH_RAMP_UP: return PH_HOLD_HI;
         PH_HOLD_HI: return PH_RAMP_DN;
         PH_RAMP_DN: return PH_HOLD_LO;
         default:    return PH_RAMP_UP;
      endcase
   endfunction

   function automatic cls_e expect_cls(phase_e p);
      case (p)
         PH_RAMP_UP: return CLS_UP;
         PH_RAMP_DN: return CLS_DOWN;
         default:    return CLS_FLAT;
      endcase
   endfunction

   phase_e                phase_q, phase_d, target;
   logic [RC_W-1:0]       run_cnt_q, run_cnt_d;
   logic [DATA_WIDTH-1:0] prev_q, prev_d, delta;
   logic                  have_prev_q, have_prev_d;
   cls_e                  last_cls_q, last_cls_d, cls;
   logic                  credit_q, credit_d;
   logic                  err_pulse_q, err_pulse_d;
   logic                  sticky_q, sticky_d;
   logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d, err_base;
   logic [CNT_WIDTH-1:0]  period_cnt_q, period_cnt_d, period_base;
   logic                  mismatch, period_inc;

   // Modulo subtraction makes +max -> -min wrap a +1 step and the reverse a -1 step.
   always_comb begin
      delta = i_data - prev_q;
      if (delta == DATA_WIDTH'(1))            cls = CLS_UP;
      else if (delta == '0)                   cls = CLS_FLAT;
      else if (delta == {DATA_WIDTH{1'b1}})   cls = CLS_DOWN;
      else                                    cls = CLS_BAD;
   end

   always_comb begin
      phase_d     = phase_q;
      run_cnt_d   = run_cnt_q;
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      last_cls_d  = last_cls_q;
      credit_d    = credit_q;
      err_pulse_d = 1'b0;
      mismatch    = 1'b0;
      period_inc  = 1'b0;
      target      = next_phase(phase_q);
      if (i_valid) begin
         prev_d = i_data;
         if (!have_prev_q) begin
            have_prev_d = 1'b1;
         end else begin
            case (phase_q)
               PH_SEEK: begin
                  if (last_cls_q == CLS_UP && cls == CLS_FLAT) begin
                     phase_d   = PH_HOLD_HI;
                     run_cnt_d = RC_W'(1);
                     credit_d  = 1'b0;
                  end else if (last_cls_q == CLS_DOWN && cls == CLS_FLAT) begin
                     phase_d   = PH_HOLD_LO;
                     run_cnt_d = RC_W'(1);
                     credit_d  = 1'b0;
                  end
                  last_cls_d = cls;
               end
               PH_RAMP_UP, PH_HOLD_HI, PH_RAMP_DN, PH_HOLD_LO: begin
                  if (run_cnt_q > RUN_LEN_C) begin
                     phase_d    = PH_SEEK;
                     last_cls_d = cls;
                  end else if (run_cnt_q == RUN_LEN_C) begin
                     if (cls == expect_cls(target)) begin
                        phase_d   = target;
                        run_cnt_d = RC_W'(1);
                        // Credit is armed by a RAMP_UP entry and spent by the next one.
                        if (target == PH_RAMP_UP) begin
                           period_inc = credit_q;
                           credit_d   = 1'b1;
                        end
                     end else begin
                        mismatch = 1'b1;
                     end
                  end else if (cls == expect_cls(phase_q)) begin
                     run_cnt_d = run_cnt_q + RC_W'(1);
                  end else begin
                     mismatch = 1'b1;
                  end
               end
               default: phase_d = PH_SEEK;
            endcase
            if (mismatch) begin
               phase_d     = PH_SEEK;
               last_cls_d  = cls;
               credit_d    = 1'b0;
               err_pulse_d = 1'b1;
            end
         end
      end
      // Clear is applied before this cycle's events.
      err_base    = i_clr ? '0 : err_cnt_q;
      period_base = i_clr ? '0 : period_cnt_q;
      sticky_d    = i_clr ? 1'b0 : sticky_q;
      err_cnt_d    = err_base;
      period_cnt_d = period_base;
      if (mismatch) begin
         sticky_d = 1'b1;
         if (err_base != {CNT_WIDTH{1'b1}}) err_cnt_d = err_base + CNT_WIDTH'(1);
      end
      if (period_inc && period_base != {CNT_WIDTH{1'b1}}) begin
         period_cnt_d = period_base + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase_q      <= PH_SEEK;
         run_cnt_q    <= '0;
         prev_q       <= '0;
         have_prev_q  <= 1'b0;
         last_cls_q   <= CLS_BAD;
         credit_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         sticky_q     <= 1'b0;
         err_cnt_q    <= '0;
         period_cnt_q <= '0;
      end else begin
         phase_q      <= phase_d;
         run_cnt_q    <= run_cnt_d;
         prev_q       <= prev_d;
         have_prev_q  <= have_prev_d;
         last_cls_q   <= last_cls_d;
         credit_q     <= credit_d;
         err_pulse_q  <= err_pulse_d;
         sticky_q     <= sticky_d;
         err_cnt_q    <= err_cnt_d;
         period_cnt_q <= period_cnt_d;
      end
   end

   assign o_locked       = (phase_q != PH_SEEK);
   assign o_phase        = phase_q;
   assign o_err_pulse    = err_pulse_q;
   assign o_err_sticky   = sticky_q;
   assign o_err_count    = err_cnt_q;
   assign o_period_count = period_cnt_q;

endmodule

// File: tb/tb_ramp_pattern_checker.sv
// Bench for ramp_pattern_checker: directed vector table, generator-driven scenarios,
// randomized stimulus against a position-based reference model, and a 4-bit wrap instance.
module tb_ramp_pattern_checker;
   localparam int DW = 16;
   localparam int HC = 3;
   localparam int RL = HC + 1;
   localparam int CW = 16;
   localparam int OW = 38;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] data;
   logic          valid, clr;
   logic          o_locked, o_err_pulse, o_err_sticky;
   logic [2:0]    o_phase;
   logic [CW-1:0] o_err_count, o_period_count;

   logic          valid4, clr4;
   logic [3:0]    data4;
   logic          locked4, pulse4, sticky4;
   logic [2:0]    phase4;
   logic [CW-1:0] errc4, perc4;

   ramp_pattern_checker #(.DATA_WIDTH(DW), .HOLD_CYCLES(HC), .CNT_WIDTH(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_clr(clr),
      .o_locked(o_locked), .o_phase(o_phase), .o_err_pulse(o_err_pulse),
      .o_err_sticky(o_err_sticky), .o_err_count(o_err_count), .o_period_count(o_period_count)
   );

   ramp_pattern_checker #(.DATA_WIDTH(4), .HOLD_CYCLES(HC), .CNT_WIDTH(CW)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data4), .i_valid(valid4), .i_clr(clr4),
      .o_locked(locked4), .o_phase(phase4), .o_err_pulse(pulse4),
      .o_err_sticky(sticky4), .o_err_count(errc4), .o_period_count(perc4)
   );

   // Clock and reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   string tag = "";
   logic [OW-1:0] exp_q[$];

   // Reference model: position since lock decides the expected step kind.
   // Kinds: 0=up 1=flat 2=down 3=other. Segment order: ramp up, hold hi, ramp dn, hold lo.
   bit          m_have, m_locked, m_ups, m_pulse, m_sticky;
   logic [15:0] m_prev, m_errc, m_perc;
   int          m_last, m_start, m_pos;

   // Trapezoid generator: sample n>0 steps by the segment ((n-1)/RL) mod 4.
   int          g_n;
   logic [15:0] g_val;

   function automatic int kind_of(logic [15:0] d);
      if (d == 16'd1) return 0;
      if (d == 16'd0) return 1;
      if (d == 16'hFFFF) return 2;
      return 3;
   endfunction

   function automatic int seg_kind(int seg);
      case (seg)
         0: return 0;
         2: return 2;
         default: return 1;
      endcase
   endfunction

   task automatic model_reset();
      m_have = 0; m_locked = 0; m_ups = 0; m_pulse = 0; m_sticky = 0;
      m_prev = '0; m_errc = '0; m_perc = '0; m_last = 3; m_start = 0; m_pos = 0;
   endtask

   task automatic model_step(input logic v, input logic c, input logic [15:0] d);
      int k, seg;
      m_pulse = 0;
      if (c) begin
         m_sticky = 0; m_errc = '0; m_perc = '0;
      end
      if (v) begin
         if (!m_have) begin
            m_have = 1;
         end else begin
            k = kind_of(d - m_prev);
            if (!m_locked) begin
               if (k == 1 && (m_last == 0 || m_last == 2)) begin
                  m_locked = 1; m_start = (m_last == 0) ? 1 : 3; m_pos = 0; m_ups = 0;
               end
               m_last = k;
            end else begin
               m_pos++;
               seg = (m_start + m_pos / RL) % 4;
               if (k != seg_kind(seg)) begin
                  m_pulse = 1; m_sticky = 1; m_locked = 0; m_last = k;
                  if (m_errc != 16'hFFFF) m_errc++;
               end else if (seg == 0 && (m_pos % RL) == 0) begin
                  if (m_ups && m_perc != 16'hFFFF) m_perc++;
                  m_ups = 1;
               end
            end
         end
         m_prev = d;
      end
   endtask

   function automatic logic [OW-1:0] model_vec();
      logic [2:0] ph;
      ph = m_locked ? 3'((m_start + m_pos / RL) % 4 + 1) : 3'd0;
      return {m_locked, ph, m_pulse, m_sticky, m_errc, m_perc};
   endfunction

   function automatic logic [OW-1:0] dut_vec();
      return {o_locked, o_phase, o_err_pulse, o_err_sticky, o_err_count, o_period_count};
   endfunction

   task automatic gen_reset(input logic [15:0] start);
      g_n = 0; g_val = start;
   endtask

   task automatic gen_next(output logic [15:0] v);
      int seg;
      if (g_n > 0) begin
         seg = ((g_n - 1) / RL) % 4;
         if (seg == 0) g_val = g_val + 16'd1;
         else if (seg == 2) g_val = g_val - 16'd1;
      end
      v = g_val;
      g_n++;
   endtask

   // Scoreboard compare helpers
   task automatic check_vec(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got lock=%0d ph=%0d pulse=%0d sticky=%0d errc=%0d per=%0d, want lock=%0d ph=%0d pulse=%0d sticky=%0d errc=%0d per=%0d",
                  name, got[37], got[36:34], got[33], got[32], got[31:16], got[15:0],
                  exp[37], exp[36:34], exp[33], exp[32], exp[31:16], exp[15:0]);
      end
   endtask

   task automatic check_val(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, exp);
      end
   endtask

   // Driver: one cycle, model-predicted outputs compared after the edge
   task automatic step(input logic v, input logic c, input logic [15:0] d);
      @(negedge clk);
      valid = v; clr = c; data = d;
      model_step(v, c, d);
      exp_q.push_back(model_vec());
      @(posedge clk);
      #1;
      check_vec(tag, dut_vec(), exp_q.pop_front());
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; valid = 1'b0; clr = 1'b0; data = '0;
      valid4 = 1'b0; clr4 = 1'b0; data4 = '0;
      model_reset();
      #2;
      check_vec({tag, "_reset"}, dut_vec(), '0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        v;
      logic        c;
      logic [15:0] d;
      logic [2:0]  ph;
      logic        pulse;
      logic        sticky;
      logic [15:0] errc;
      logic [15:0] per;
   } vec_t;

   function automatic vec_t mk(int v, int c, int d, int ph, int p, int s, int e, int pr);
      vec_t r;
      r.v = 1'(v); r.c = 1'(c); r.d = 16'(d); r.ph = 3'(ph);
      r.pulse = 1'(p); r.sticky = 1'(s); r.errc = 16'(e); r.per = 16'(pr);
      return r;
   endfunction

   initial begin
      vec_t        tbl[19];
      logic [15:0] v;
      int          lock_at, cnt, r;

      tbl[0]  = mk(1, 0, 10, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 11, 0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 0, 11, 2, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 11, 2, 0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 99, 2, 0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 11, 2, 0, 0, 0, 0);
      tbl[6]  = mk(1, 0, 11, 2, 0, 0, 0, 0);
      tbl[7]  = mk(1, 0, 10, 3, 0, 0, 0, 0);
      tbl[8]  = mk(1, 0, 15, 0, 1, 1, 1, 0);
      tbl[9]  = mk(1, 0, 15, 0, 0, 1, 1, 0);
      tbl[10] = mk(1, 0, 14, 0, 0, 1, 1, 0);
      tbl[11] = mk(1, 0, 14, 4, 0, 1, 1, 0);
      tbl[12] = mk(1, 0, 14, 4, 0, 1, 1, 0);
      tbl[13] = mk(1, 0, 14, 4, 0, 1, 1, 0);
      tbl[14] = mk(1, 0, 14, 4, 0, 1, 1, 0);
      tbl[15] = mk(1, 0, 15, 1, 0, 1, 1, 0);
      tbl[16] = mk(1, 1, 16, 1, 0, 0, 0, 0);
      tbl[17] = mk(1, 1, 16, 0, 1, 1, 1, 0);
      tbl[18] = mk(0, 1, 0,  0, 0, 0, 0, 0);

      rst_n = 1'b1; valid = 1'b0; clr = 1'b0; data = '0;
      valid4 = 1'b0; clr4 = 1'b0; data4 = '0;
      model_reset();

      // Directed vector table
      tag = "table";
      do_reset();
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         valid = tbl[i].v; clr = tbl[i].c; data = tbl[i].d;
         @(posedge clk);
         #1;
         check_vec($sformatf("table_row%0d", i), dut_vec(),
                   {(tbl[i].ph != 3'd0), tbl[i].ph, tbl[i].pulse, tbl[i].sticky, tbl[i].errc, tbl[i].per});
      end

      // Clean stream: lock quickly, nine credited periods
      tag = "clean";
      do_reset();
      gen_reset(16'd0);
      lock_at = -1;
      for (int i = 0; i < 162; i++) begin
         gen_next(v);
         step(1'b1, 1'b0, v);
         if (o_locked && lock_at < 0) lock_at = i + 1;
      end
      check_val("clean_lock_within_10", (lock_at > 0 && lock_at <= 10) ? 1 : 0, 1);
      check_val("clean_err_count", int'(o_err_count), 0);
      check_val("clean_period_count", int'(o_period_count), 9);
      check_val("clean_sticky", int'(o_err_sticky), 0);

      // Valid toggling does not change the outcome
      tag = "toggle";
      do_reset();
      gen_reset(16'd0);
      for (int i = 0; i < 162; i++) begin
         gen_next(v);
         step(1'b1, 1'b0, v);
         step(1'b0, 1'b0, 16'($urandom));
      end
      check_val("toggle_err_count", int'(o_err_count), 0);
      check_val("toggle_period_count", int'(o_period_count), 9);

      // Stretched HOLD_HI: fifth flat sample is an error, period credit lost
      tag = "stretch";
      do_reset();
      gen_reset(16'd100);
      for (int i = 0; i < 25; i++) begin
         gen_next(v);
         step(1'b1, 1'b0, v);
      end
      step(1'b1, 1'b0, g_val);
      check_val("stretch_pulse", int'(o_err_pulse), 1);
      check_val("stretch_phase_seek", int'(o_phase), 0);
      check_val("stretch_err_count", int'(o_err_count), 1);
      lock_at = -1;
      cnt = 0;
      while (g_n <= 49) begin
         gen_next(v);
         step(1'b1, 1'b0, v);
         cnt++;
         if (o_locked && lock_at < 0) lock_at = cnt;
      end
      check_val("stretch_relock_bound", (lock_at > 0 && lock_at <= 2 * RL + 2) ? 1 : 0, 1);
      check_val("stretch_period_count", int'(o_period_count), 1);
      check_val("stretch_sticky", int'(o_err_sticky), 1);

      // 4-bit instance: ramps through the signed wrap
      tag = "wrap4";
      do_reset();
      gen_reset(16'd5);
      for (int i = 0; i < 50; i++) begin
         gen_next(v);
         @(negedge clk);
         valid4 = 1'b1; data4 = v[3:0];
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      valid4 = 1'b0;
      check_val("wrap4_err_count", int'(errc4), 0);
      check_val("wrap4_sticky", int'(sticky4), 0);
      check_val("wrap4_locked", int'(locked4), 1);
      check_val("wrap4_phase", int'(phase4), 1);
      check_val("wrap4_period_count", int'(perc4), 2);

      // Randomized stimulus against the reference model
      tag = "random";
      do_reset();
      gen_reset(16'($urandom));
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            step(1'b0, ($urandom_range(0, 49) == 0), 16'($urandom));
         end else begin
            r = $urandom_range(0, 99);
            if (r < 3) v = g_val + 16'($urandom_range(1, 5));
            else if (r < 5) v = g_val;
            else gen_next(v);
            step(1'b1, ($urandom_range(0, 49) == 0), v);
         end
      end

      // Asynchronous reset in the middle of a locked run
      tag = "midreset";
      do_reset();
      gen_reset(16'd7);
      for (int i = 0; i < 20; i++) begin
         gen_next(v);
         step(1'b1, 1'b0, v);
      end
      step(1'b1, 1'b0, g_val + 16'd5);
      for (int i = 0; i < 12; i++) begin
         gen_next(v);
         step(1'b1, 1'b0, v);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("midreset_async_zero", dut_vec(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      lock_at = -1;
      for (int i = 0; i < 30; i++) begin
         gen_next(v);
         step(1'b1, 1'b0, v);
         if (o_locked && lock_at < 0) lock_at = i + 1;
      end
      check_val("midreset_relocked", (lock_at > 0) ? 1 : 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
